sprite_table: RTL and testbench

Double-buffered sprite attribute table with a per-pixel hit resolver for the VGA sprite path. It generalises the fixed two-sprite latch to `N_SPRITES` entries written one at a time into a shadow bank. The shadow bank is committed to the active bank only at vertical-blank start, so a frame never shows a half-updated sprite set. Each pixel, it resolves which sprite covers the current beam position and emits that sprite's image id and ROM address to the sprite ROM/compositor downstream.

---
 rtl/sprite_table_pkg.sv | 23 ++
 rtl/sprite_table_if.sv | 33 +++
 rtl/sprite_table_hit_resolver.sv | 65 ++++++
 rtl/sprite_table.sv | 125 ++++++++++++
 tb/tb_sprite_table.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sprite_table_pkg.sv
// Shared types and constants for the double-buffered sprite attribute table.
//   sprite_attr_t  : one table entry {image_id, y, x}
//   IMG_DISABLED   : image id that marks an entry as unused
//   COORD_W        : beam / sprite coordinate width
//   commit_state_t : states of the shadow-to-active commit machine
package sprite_pkg;

  localparam int COORD_W = 10;

  localparam logic [3:0] IMG_DISABLED = 4'h0;

  typedef struct packed {
    logic [3:0]         image_id;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } sprite_attr_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

endpackage

// File: rtl/sprite_table_if.sv
// Bus bundle for sprite_table: shadow-bank write port, commit/vblank control,
// beam position in, and the resolved pixel result plus status out.
//   master : drives write/wr_index/wr_data/commit/vblank/hcount/vcount
//   slave  : the table itself, drives status and resolver outputs
interface sprite_table_if #(
  parameter int IDX_W  = 5,
  parameter int ROM_AW = 10
);
  logic              write;
  logic [IDX_W-1:0]  wr_index;
  logic [23:0]       wr_data;
  logic              commit;
  logic              vblank;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic              commit_pending;
  logic              commit_done;
  logic              wr_err;
  logic              hit;
  logic [IDX_W-1:0]  hit_index;
  logic [3:0]        hit_image;
  logic [ROM_AW-1:0] rom_addr;

  modport master (
    output write, wr_index, wr_data, commit, vblank, hcount, vcount,
    input  commit_pending, commit_done, wr_err, hit, hit_index, hit_image, rom_addr
  );

  modport slave (
    input  write, wr_index, wr_data, commit, vblank, hcount, vcount,
    output commit_pending, commit_done, wr_err, hit, hit_index, hit_image, rom_addr
  );
endinterface

// File: rtl/sprite_table_hit_resolver.sv
// Combinational per-pixel hit resolver over the active sprite bank.
// Ports:
//   i_active     : active bank entries
//   i_hcount/vcount : beam position
//   o_hit, o_index, o_image, o_rom_addr : lowest-index covering sprite,
//                  all zero when nothing covers the beam
module sprite_hit_resolver
  import sprite_pkg::*;
#(
  parameter int N_SPRITES   = 20,
  parameter int SPRITE_SIZE = 32,
  parameter int IDX_W       = 5,
  parameter int ROM_AW      = 10
) (
  input  sprite_attr_t       i_active [N_SPRITES],
  input  logic [COORD_W-1:0] i_hcount,
  input  logic [COORD_W-1:0] i_vcount,
  output logic               o_hit,
  output logic [IDX_W-1:0]   o_index,
  output logic [3:0]         o_image,
  output logic [ROM_AW-1:0]  o_rom_addr
);

  localparam int SZ_W = $clog2(SPRITE_SIZE);

  logic [N_SPRITES-1:0] w_cover;
  logic [ROM_AW-1:0]    w_addr [N_SPRITES];
  logic [COORD_W-1:0]   w_dx   [N_SPRITES];
  logic [COORD_W-1:0]   w_dy   [N_SPRITES];
  logic                 w_found;

  // Compare in 11 bits so a sprite near column/row 1023 is clipped rather
  // than wrapping back to 0.
  always_comb begin
    for (int i = 0; i < N_SPRITES; i++) begin
      w_dx[i]    = i_hcount - i_active[i].x;
      w_dy[i]    = i_vcount - i_active[i].y;
      w_cover[i] = (i_active[i].image_id != IMG_DISABLED)
                && ({1'b0, i_hcount} >= {1'b0, i_active[i].x})
                && ({1'b0, i_hcount} <  {1'b0, i_active[i].x} + 11'(SPRITE_SIZE))
                && ({1'b0, i_vcount} >= {1'b0, i_active[i].y})
                && ({1'b0, i_vcount} <  {1'b0, i_active[i].y} + 11'(SPRITE_SIZE));
      // SPRITE_SIZE is a power of two, so the multiply is a shift.
      w_addr[i]  = ROM_AW'((20'(w_dy[i]) << SZ_W) + 20'(w_dx[i]));
    end
  end

  always_comb begin
    o_hit      = 1'b0;
    o_index    = '0;
    o_image    = '0;
    o_rom_addr = '0;
    w_found    = 1'b0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (w_cover[i] && !w_found) begin
        w_found    = 1'b1;
        o_hit      = 1'b1;
        o_index    = IDX_W'(i);
        o_image    = i_active[i].image_id;
        o_rom_addr = w_addr[i];
      end
    end
  end

endmodule

// File: rtl/sprite_table.sv
// Double-buffered sprite attribute table. Writes land in a shadow bank; a
// commit request is held until the next vblank rising edge, when the whole
// shadow bank is copied into the active bank. Each cycle the active bank is
// resolved against the beam position and the result is registered.
// Ports:
//   clk   : pixel clock
//   reset : synchronous, active low
//   bus   : sprite_table_if slave (write port, commit/vblank, beam, results)
//
// state   | meaning
// IDLE    | no commit outstanding
// PENDING | commit requested, waiting for vblank rising edge
module sprite_table
  import sprite_pkg::*;
#(
  parameter int N_SPRITES   = 20,
  parameter int SPRITE_SIZE = 32,
  parameter int IDX_W       = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
  parameter int ROM_AW      = 2 * $clog2(SPRITE_SIZE)
) (
  input logic           clk,
  input logic           reset,
  sprite_table_if.slave bus
);

  localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_SPRITES);

  sprite_attr_t  r_shadow [N_SPRITES];
  sprite_attr_t  r_active [N_SPRITES];
  commit_state_t r_state;
  logic          r_vblank_d;
  logic          r_commit_done;
  logic          r_wr_err;
  logic          r_hit;
  logic [IDX_W-1:0]  r_hit_index;
  logic [3:0]        r_hit_image;
  logic [ROM_AW-1:0] r_rom_addr;

  logic              w_vb_rise;
  logic              w_wr_ok;
  logic              w_hit;
  logic [IDX_W-1:0]  w_hit_index;
  logic [3:0]        w_hit_image;
  logic [ROM_AW-1:0] w_rom_addr;

  assign w_vb_rise = bus.vblank && !r_vblank_d;
  assign w_wr_ok   = ({1'b0, bus.wr_index} < N_LIM);

  sprite_hit_resolver #(
    .N_SPRITES  (N_SPRITES),
    .SPRITE_SIZE(SPRITE_SIZE),
    .IDX_W      (IDX_W),
    .ROM_AW     (ROM_AW)
  ) u_resolver (
    .i_active  (r_active),
    .i_hcount  (bus.hcount),
    .i_vcount  (bus.vcount),
    .o_hit     (w_hit),
    .o_index   (w_hit_index),
    .o_image   (w_hit_image),
    .o_rom_addr(w_rom_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_vblank_d    <= 1'b0;
      r_commit_done <= 1'b0;
      r_wr_err      <= 1'b0;
      r_hit         <= 1'b0;
      r_hit_index   <= '0;
      r_hit_image   <= '0;
      r_rom_addr    <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_vblank_d    <= bus.vblank;
      r_commit_done <= 1'b0;

      if (bus.write) begin
        if (w_wr_ok) r_shadow[bus.wr_index] <= sprite_attr_t'(bus.wr_data);
        else         r_wr_err <= 1'b1;
      end

      // The copy reads r_shadow before this edge's write, so a write in the
      // swap cycle only shows up at the following commit.
      case (r_state)
        IDLE: begin
          if (bus.commit) begin
            if (w_vb_rise) begin
              for (int i = 0; i < N_SPRITES; i++) r_active[i] <= r_shadow[i];
              r_commit_done <= 1'b1;
            end else begin
              r_state <= PENDING;
            end
          end
        end
        PENDING: begin
          if (w_vb_rise) begin
            for (int i = 0; i < N_SPRITES; i++) r_active[i] <= r_shadow[i];
            r_commit_done <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      r_hit       <= w_hit;
      r_hit_index <= w_hit_index;
      r_hit_image <= w_hit_image;
      r_rom_addr  <= w_rom_addr;
    end
  end

  assign bus.commit_pending = (r_state == PENDING);
  assign bus.commit_done    = r_commit_done;
  assign bus.wr_err         = r_wr_err;
  assign bus.hit            = r_hit;
  assign bus.hit_index      = r_hit_index;
  assign bus.hit_image      = r_hit_image;
  assign bus.rom_addr       = r_rom_addr;

endmodule

// File: tb/tb_sprite_table.sv
// Directed bench for sprite_table with N_SPRITES=20, SPRITE_SIZE=32.
module tb_sprite_table;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc;

  always #5 clk = ~clk;

  sprite_table_if #(.IDX_W(5), .ROM_AW(10)) bus ();

  sprite_table #(.N_SPRITES(20), .SPRITE_SIZE(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int img, input int y, input int x);
    bus.write    = 1'b1;
    bus.wr_index = 5'(idx);
    bus.wr_data  = {4'(img), 10'(y), 10'(x)};
    tick();
    bus.write    = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  task automatic vb_pulse(input string tag);
    bus.vblank = 1'b1;
    tick();
    check({tag, "_done"}, 32'(bus.commit_done), 32'd1);
    bus.vblank = 1'b0;
    tick();
  endtask

  task automatic beam(input int h, input int v);
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    tick();
  endtask

  task automatic check_res(input string tag, input int h, input int v,
                           input int ehit, input int eidx, input int eimg, input int eaddr);
    beam(h, v);
    check({tag, "_hit"},  32'(bus.hit),       32'(ehit));
    check({tag, "_idx"},  32'(bus.hit_index), 32'(eidx));
    check({tag, "_img"},  32'(bus.hit_image), 32'(eimg));
    check({tag, "_addr"}, 32'(bus.rom_addr),  32'(eaddr));
  endtask

  initial begin
    reset        = 1'b0;
    bus.write    = 1'b0;
    bus.wr_index = '0;
    bus.wr_data  = '0;
    bus.commit   = 1'b0;
    bus.vblank   = 1'b0;
    bus.hcount   = '0;
    bus.vcount   = '0;
    repeat (3) tick();
    check("rst_pending", 32'(bus.commit_pending), 32'd0);
    check("rst_done",    32'(bus.commit_done),    32'd0);
    check("rst_wr_err",  32'(bus.wr_err),         32'd0);
    check("rst_hit",     32'(bus.hit),            32'd0);
    check("rst_addr",    32'(bus.rom_addr),       32'd0);
    reset = 1'b1;
    tick();

    // Idle sweep over the visible area on an 8-pixel grid.
    acc = 0;
    for (int v = 0; v < 480; v += 8) begin
      for (int h = 0; h < 640; h += 8) begin
        beam(h, v);
        if (bus.hit || bus.hit_index != 0 || bus.hit_image != 0 || bus.rom_addr != 0) acc++;
      end
    end
    check("idle_sweep_nonzero", 32'(acc), 32'd0);

    // Commit deferred until vblank.
    wr(3, 2, 100, 200);
    do_commit();
    check("defer_pending", 32'(bus.commit_pending), 32'd1);
    check_res("defer_nohit", 200, 100, 0, 0, 0, 0);
    bus.vblank = 1'b1;
    tick();
    check("defer_done", 32'(bus.commit_done), 32'd1);
    check("defer_pending_clr", 32'(bus.commit_pending), 32'd0);
    tick();
    check("defer_done_once", 32'(bus.commit_done), 32'd0);
    bus.vblank = 1'b0;
    tick();
    check_res("corner", 231, 131, 1, 3, 2, 1023);
    check_res("origin", 200, 100, 1, 3, 2, 0);
    check_res("right_out", 232, 100, 0, 0, 0, 0);

    // Priority: lowest index wins.
    wr(1, 5, 50, 50);
    wr(7, 9, 60, 60);
    do_commit();
    vb_pulse("prio");
    check_res("prio_overlap", 65, 65, 1, 1, 5, 495);
    check_res("prio_e7_only", 85, 85, 1, 7, 9, 825);

    // Write in the same cycle as the swap lands only in shadow.
    wr(0, 4, 300, 300);
    do_commit();
    bus.vblank   = 1'b1;
    bus.write    = 1'b1;
    bus.wr_index = 5'd0;
    bus.wr_data  = {4'd6, 10'd300, 10'd300};
    tick();
    check("coll_done", 32'(bus.commit_done), 32'd1);
    bus.write  = 1'b0;
    bus.vblank = 1'b0;
    tick();
    check_res("coll_old", 300, 300, 1, 0, 4, 0);
    do_commit();
    vb_pulse("coll2");
    check_res("coll_new", 300, 300, 1, 0, 6, 0);

    // Out-of-range index is dropped and sets a sticky error.
    wr(25, 7, 0, 0);
    check("bad_wr_err", 32'(bus.wr_err), 32'd1);
    repeat (3) tick();
    check("bad_wr_sticky", 32'(bus.wr_err), 32'd1);
    do_commit();
    vb_pulse("bad");
    check_res("bad_no_entry", 0, 0, 0, 0, 0, 0);

    // Right-edge clipping: no wrap to column 0.
    wr(2, 3, 0, 1010);
    do_commit();
    vb_pulse("clip");
    check_res("clip_in", 1015, 5, 1, 2, 3, 165);
    check_res("clip_edge", 1023, 31, 1, 2, 3, 1005);
    acc = 0;
    for (int h = 0; h < 10; h++) begin
      beam(h, 5);
      if (bus.hit) acc++;
    end
    check("clip_no_wrap", 32'(acc), 32'd0);

    // Reset while a commit is pending discards it.
    wr(5, 8, 400, 400);
    do_commit();
    check("mid_pending", 32'(bus.commit_pending), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_pending_clr", 32'(bus.commit_pending), 32'd0);
    check("mid_wr_err_clr", 32'(bus.wr_err), 32'd0);
    tick();
    bus.vblank = 1'b1;
    tick();
    check("mid_no_done", 32'(bus.commit_done), 32'd0);
    tick();
    check("mid_no_done2", 32'(bus.commit_done), 32'd0);
    bus.vblank = 1'b0;
    tick();
    check_res("mid_empty_a", 400, 400, 0, 0, 0, 0);
    check_res("mid_empty_b", 65, 65, 0, 0, 0, 0);

    // Commit in the same cycle as the vblank rising edge swaps immediately.
    wr(5, 8, 400, 400);
    bus.commit = 1'b1;
    bus.vblank = 1'b1;
    tick();
    bus.commit = 1'b0;
    check("same_done", 32'(bus.commit_done), 32'd1);
    check("same_pending", 32'(bus.commit_pending), 32'd0);
    bus.vblank = 1'b0;
    tick();
    check_res("same_hit", 410, 420, 1, 5, 8, 20 * 32 + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
